// File: rtl/instruction_fetch.sv
// Fetch stage: reads the word at the PC over the instruction bus, holds it for decode
// and pulses the PC's count enable once per fetch. Optional FETCH_TIMEOUT_EN aborts stalled reads.
`timescale 1ns/1ps

module instruction_fetch #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pcValue,
  input  logic                  fetchStart,
  output logic [ADDR_WIDTH-1:0] busAddress,
  output logic                  busReadRequest,
  input  logic                  busReady,
  input  logic [DATA_WIDTH-1:0] busDataIn,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instructionValid,
  input  logic                  instructionAccept,
  output logic                  pcCountEnable,
  output logic                  fetchError,
  output logic                  fetchBusy
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("instruction_fetch: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQUEST, HOLD} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;
  logic                  pce_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  pc_aligned;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0]            tcnt_q;
`endif

  assign pc_aligned = (pcValue[1:0] == 2'b00);

  // Pulsed outputs (pce_q, err_q) default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bus_addr_q <= '0;
      req_q      <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      pce_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tcnt_q     <= 8'd0;
`endif
    end else begin
      pce_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetchStart) begin
            if (pc_aligned) begin
              bus_addr_q <= pcValue;
              req_q      <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= REQUEST;
`ifdef FETCH_TIMEOUT_EN
              tcnt_q     <= 8'd0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        REQUEST: begin
          if (busReady) begin
            instr_q <= busDataIn;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            pce_q   <= 1'b1;
            state_q <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (8'(tcnt_q + 8'd1) >= TIMEOUT_LIMIT) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tcnt_q <= 8'(tcnt_q + 8'd1);
          end
`endif
        end
        HOLD: begin
          // pcValue is stale while pce_q is high, so no chained fetch that cycle.
          if (instructionAccept) begin
            valid_q <= 1'b0;
            if (!pce_q && fetchStart && pc_aligned) begin
              bus_addr_q <= pcValue;
              req_q      <= 1'b1;
              state_q    <= REQUEST;
`ifdef FETCH_TIMEOUT_EN
              tcnt_q     <= 8'd0;
`endif
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busAddress       = bus_addr_q;
  assign busReadRequest   = req_q;
  assign instruction      = instr_q;
  assign instructionValid = valid_q;
  assign pcCountEnable    = pce_q;
  assign fetchError       = err_q;
  assign fetchBusy        = busy_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run checked against
// a transaction-level model (PC sequence, memory contents, pulse counts).
`timescale 1ns/1ps

module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcValue;
  logic        fetchStart;
  logic [31:0] busAddress;
  logic        busReadRequest;
  logic        busReady;
  logic [31:0] busDataIn;
  logic [31:0] instruction;
  logic        instructionValid;
  logic        instructionAccept;
  logic        pcCountEnable;
  logic        fetchError;
  logic        fetchBusy;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pcValue          (pcValue),
    .fetchStart       (fetchStart),
    .busAddress       (busAddress),
    .busReadRequest   (busReadRequest),
    .busReady         (busReady),
    .busDataIn        (busDataIn),
    .instruction      (instruction),
    .instructionValid (instructionValid),
    .instructionAccept(instructionAccept),
    .pcCountEnable    (pcCountEnable),
    .fetchError       (fetchError),
    .fetchBusy        (fetchBusy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: a ProgramCounter model and fetch bookkeeping.
  logic [31:0] pc_reg   = 32'd0;
  logic [31:0] exp_addr = 32'd0;
  bit          wired    = 1'b0;
  bit          auto_mem = 1'b0;
  bit          chk_on   = 1'b0;
  int unsigned n_pce    = 0;
  int unsigned n_comp   = 0;
  int unsigned n_double = 0;
  int unsigned n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock: snapshot pre-edge outputs, advance, then update the reference model.
  task automatic tick();
    logic        pre_req, pre_rdy, pre_pce, pre_valid, pre_acc;
    logic [31:0] pre_addr, pre_instr;
    pre_req   = busReadRequest;
    pre_rdy   = busReady;
    pre_pce   = pcCountEnable;
    pre_valid = instructionValid;
    pre_acc   = instructionAccept;
    pre_addr  = busAddress;
    pre_instr = instruction;
    @(posedge clk);
    #1;
    if (pre_pce) begin
      pc_reg = pc_reg + 32'd4;
      n_pce++;
      if (pcCountEnable) n_double++;
    end
    if (pre_req && pre_rdy) begin
      n_comp++;
      if (chk_on) begin
        check("fetch_addr", pre_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        check("fetch_instr", instruction, memfn(pre_addr));
        check("fetch_valid", 32'(instructionValid), 32'd1);
        check("fetch_pce", 32'(pcCountEnable), 32'd1);
      end
    end
    if (chk_on && pre_valid && !pre_acc) begin
      check("hold_valid", 32'(instructionValid), 32'd1);
      check("hold_instr", instruction, pre_instr);
    end
    if (chk_on && fetchError) n_err++;
    if (wired) pcValue = pc_reg;
    if (auto_mem) busDataIn = memfn(busAddress);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] prev_instr;
    logic [31:0] pc_start;
    int unsigned waitc;

    reset = 1'b1;
    pcValue = 32'd0;
    fetchStart = 1'b0;
    busReady = 1'b0;
    busDataIn = 32'd0;
    instructionAccept = 1'b0;

    // Reset values
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_addr", busAddress, 32'd0);
    check("rst_req", 32'(busReadRequest), 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_valid", 32'(instructionValid), 32'd0);
    check("rst_flags", 32'({pcCountEnable, fetchError, fetchBusy}), 32'd0);
    reset = 1'b0;

    // Zero-wait fetch at 0
    pcValue = 32'd0; fetchStart = 1'b1; busReady = 1'b1; busDataIn = 32'h0000_0013;
    n_pce = 0;
    tick();
    fetchStart = 1'b0;
    check("zw_addr", busAddress, 32'd0);
    check("zw_req", 32'(busReadRequest), 32'd1);
    check("zw_busy", 32'(fetchBusy), 32'd1);
    check("zw_valid_early", 32'(instructionValid), 32'd0);
    tick();
    check("zw_instr", instruction, 32'h0000_0013);
    check("zw_valid", 32'(instructionValid), 32'd1);
    check("zw_pce", 32'(pcCountEnable), 32'd1);
    check("zw_req_drop", 32'(busReadRequest), 32'd0);
    check("zw_err", 32'(fetchError), 32'd0);
    tick();
    check("zw_pce_off", 32'(pcCountEnable), 32'd0);
    check("zw_valid_held", 32'(instructionValid), 32'd1);
    check("zw_pce_count", 32'(n_pce), 32'd1);
    busReady = 1'b0; instructionAccept = 1'b1;
    tick();
    instructionAccept = 1'b0;
    check("zw_accepted", 32'(instructionValid), 32'd0);
    check("zw_idle", 32'(fetchBusy), 32'd0);
    check("zw_instr_kept", instruction, 32'h0000_0013);

    // Wait-state fetch
    pcValue = 32'hDEAD_BEEC; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    check("ws_addr", busAddress, 32'hDEAD_BEEC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_req_held", 32'(busReadRequest), 32'd1);
      check("ws_addr_stable", busAddress, 32'hDEAD_BEEC);
      check("ws_no_valid", 32'(instructionValid), 32'd0);
    end
    busReady = 1'b1; busDataIn = 32'h00A0_0093;
    tick();
    busReady = 1'b0;
    check("ws_instr", instruction, 32'h00A0_0093);
    check("ws_valid", 32'(instructionValid), 32'd1);
    check("ws_req_drop", 32'(busReadRequest), 32'd0);
    instructionAccept = 1'b1;
    tick();
    instructionAccept = 1'b0;

    // Misaligned PC
    pcValue = 32'hDEAD_BEEF; fetchStart = 1'b1; n_pce = 0;
    tick();
    fetchStart = 1'b0;
    check("mis_err", 32'(fetchError), 32'd1);
    check("mis_req", 32'(busReadRequest), 32'd0);
    check("mis_busy", 32'(fetchBusy), 32'd0);
    check("mis_pce", 32'(pcCountEnable), 32'd0);
    tick();
    check("mis_err_pulse", 32'(fetchError), 32'd0);
    check("mis_pce_count", 32'(n_pce), 32'd0);

    // Asynchronous reset in the middle of a request
    pcValue = 32'h0000_0100; fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    check("ar_req_before", 32'(busReadRequest), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("ar_req", 32'(busReadRequest), 32'd0);
    check("ar_busy", 32'(fetchBusy), 32'd0);
    check("ar_valid", 32'(instructionValid), 32'd0);
    reset = 1'b0;
    pcValue = 32'd0; fetchStart = 1'b1; busReady = 1'b1; busDataIn = 32'h1234_5678;
    tick();
    fetchStart = 1'b0;
    tick();
    check("ar_refetch_instr", instruction, 32'h1234_5678);
    check("ar_refetch_valid", 32'(instructionValid), 32'd1);
    busReady = 1'b0; instructionAccept = 1'b1;
    tick();
    instructionAccept = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    // Timeout after 4 REQUEST cycles without busReady
    prev_instr = instruction;
    pcValue = 32'h0000_0040; fetchStart = 1'b1; n_pce = 0;
    tick();
    fetchStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_err", 32'(fetchError), 32'd0);
      check("to_wait_req", 32'(busReadRequest), 32'd1);
    end
    tick();
    check("to_err", 32'(fetchError), 32'd1);
    check("to_req", 32'(busReadRequest), 32'd0);
    check("to_busy", 32'(fetchBusy), 32'd0);
    check("to_instr", instruction, prev_instr);
    tick();
    check("to_err_pulse", 32'(fetchError), 32'd0);
    check("to_pce_count", 32'(n_pce), 32'd0);
    // busReady on the 4th cycle wins over the timeout
    fetchStart = 1'b1;
    tick();
    fetchStart = 1'b0;
    repeat (3) tick();
    busReady = 1'b1; busDataIn = 32'hCAFE_0013;
    tick();
    busReady = 1'b0;
    check("to_ok_err", 32'(fetchError), 32'd0);
    check("to_ok_instr", instruction, 32'hCAFE_0013);
    check("to_ok_pce", 32'(pcCountEnable), 32'd1);
    instructionAccept = 1'b1;
    tick();
    instructionAccept = 1'b0;
`endif

    // Program counter wired in, zero-wait memory, 8 fetches
    do_reset();
    pc_reg = 32'd4; exp_addr = 32'd4; pcValue = 32'd4;
    wired = 1'b1; auto_mem = 1'b1; chk_on = 1'b1;
    busDataIn = memfn(busAddress);
    n_pce = 0; n_comp = 0; n_double = 0; n_err = 0;
    fetchStart = 1'b1; instructionAccept = 1'b1; busReady = 1'b1;
    for (int cyc = 0; cyc < 100 && n_comp < 8; cyc++) begin
      tick();
      if (n_comp >= 8) fetchStart = 1'b0;
    end
    fetchStart = 1'b0;
    check("b2b_fetches", 32'(n_comp), 32'd8);
    repeat (4) tick();
    check("b2b_pce_count", 32'(n_pce), 32'd8);
    check("b2b_final_pc", pc_reg, 32'd36);
    check("b2b_last_addr", exp_addr, 32'd36);
    check("b2b_errors", 32'(n_err), 32'd0);

    // Randomized run against the transaction model
    wired = 1'b0;
    do_reset();
    pc_start = $urandom & 32'hFFFF_FFFC;
    pc_reg = pc_start; exp_addr = pc_start; pcValue = pc_start;
    wired = 1'b1;
    busDataIn = memfn(busAddress);
    n_pce = 0; n_comp = 0; n_double = 0; n_err = 0; waitc = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      fetchStart        = ($urandom_range(0, 3) != 0);
      instructionAccept = ($urandom_range(0, 2) != 0);
      if (busReadRequest) begin
        busReady = (waitc >= 2) || ($urandom_range(0, 1) == 1);
        waitc    = busReady ? 0 : waitc + 1;
      end else begin
        busReady = ($urandom_range(0, 1) == 1);
        waitc    = 0;
      end
      tick();
    end
    fetchStart = 1'b0; instructionAccept = 1'b1; busReady = 1'b1;
    repeat (6) tick();
    check("rnd_some_fetches", 32'(n_comp != 0), 32'd1);
    check("rnd_pce_vs_fetch", 32'(n_pce), 32'(n_comp));
    check("rnd_final_pc", pc_reg, pc_start + 32'(4 * n_comp));
    check("rnd_pce_double", 32'(n_double), 32'd0);
    check("rnd_errors", 32'(n_err), 32'd0);
    check("rnd_drained", 32'({fetchBusy, instructionValid, busReadRequest}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the PC value (the PC's dataOut), issues a word read on the instruction bus and latches the returned instruction.
- Holds the instruction until the decode/control stage accepts it.
- Pulses the PC's countEnable exactly once per successful fetch, so the PC advances by 4.

Parameters:
- ADDR_WIDTH, 32, width of PC and bus address.
- DATA_WIDTH, 32, width of instruction word and bus data.
- TIMEOUT_CYCLES, 16, max REQUEST cycles before abort. Used only with FETCH_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcValue  in  ADDR_WIDTH  current PC (ProgramCounter dataOut).
- fetchStart  in  1  level request from control to fetch at pcValue.
- busAddress  out  ADDR_WIDTH  instruction bus read address.
- busReadRequest  out  1  read request; held until busReady.
- busReady  in  1  memory has valid data on busDataIn this cycle.
- busDataIn  in  DATA_WIDTH  read data.
- instruction  out  DATA_WIDTH  latched instruction word.
- instructionValid  out  1  instruction holds a fetched, unaccepted word.
- instructionAccept  in  1  consumer takes instruction this cycle.
- pcCountEnable  out  1  one-cycle pulse to ProgramCounter countEnable.
- fetchError  out  1  one-cycle pulse on misaligned PC (or timeout).
- fetchBusy  out  1  high in REQUEST or HOLD.

Behaviour:
- All outputs are registered.
- Reset (async, any state) forces:
  - state IDLE;
  - busAddress=0, busReadRequest=0, instruction=0;
  - instructionValid=0, pcCountEnable=0, fetchError=0, fetchBusy=0;
  - timeout counter=0.
  - A reset mid-REQUEST drops the request immediately; the bench must not expect busReady to be honoured.
- FSM states: IDLE, REQUEST, HOLD.
- IDLE:
  - fetchStart=1 and pcValue[1:0]==0: next edge latches busAddress=pcValue, busReadRequest=1, goes to REQUEST.
  - fetchStart=1 and pcValue[1:0]!=0: fetchError=1 for one cycle, stay IDLE, no bus request, no pcCountEnable.
  - busReady is ignored.
- REQUEST:
  - busAddress stays stable and busReadRequest stays 1 until the edge where busReady=1.
  - On that edge: instruction<=busDataIn, busReadRequest<=0, instructionValid<=1, pcCountEnable<=1, go to HOLD.
  - Latency: busReady sampled at edge N gives instruction, instructionValid and pcCountEnable visible after edge N.
  - Zero-wait memory (busReady already high at the first REQUEST edge) therefore gives 2 edges from fetchStart to instructionValid.
- HOLD:
  - pcCountEnable is high only during the first HOLD cycle; the PC updates at the end of that cycle.
  - instruction and instructionValid stay held until instructionAccept=1.
  - instructionAccept=1 with pcCountEnable=0 and fetchStart=1 (aligned pcValue): back-to-back fetch. instructionValid<=0, latch the new busAddress, go to REQUEST.
  - instructionAccept=1 otherwise: instructionValid<=0, go to IDLE.
  - instructionAccept with pcCountEnable=1 never starts a new fetch, because pcValue is stale that cycle.
  - busReady is ignored.
- instruction keeps its last value after accept; it is not cleared.
- pcCountEnable is never high for more than one consecutive cycle and is never asserted on error.
- fetchBusy = (state != IDLE).
- No address arithmetic: the PC owns the +4 increment; wrap at 0xFFFFFFFC is the PC's behaviour and is transparent here.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to REQUEST and increments each REQUEST cycle without busReady.
  - When it reaches TIMEOUT_CYCLES without busReady: busReadRequest<=0, fetchError pulses 1 cycle, go to IDLE, no pcCountEnable, instruction unchanged.
  - busReady on the same edge as the timeout wins: a normal completion occurs.
- Not defined: no counter logic; REQUEST waits indefinitely and fetchError reports misalignment only.

Test Plan:
- Reset=1, then pcValue=0x00000000, fetchStart=1, busReady=1 with busDataIn=0x00000013 → busAddress=0, instruction=0x00000013, instructionValid=1, a single pcCountEnable pulse, fetchError=0.
- pcValue=0xDEADBEEC, busReady delayed 3 cycles, busDataIn=0x00A00093 → busReadRequest held 3 cycles with busAddress stable at 0xDEADBEEC, then instruction=0x00A00093.
- Misaligned fetch: pcValue=0xDEADBEEF, fetchStart=1 → fetchError pulses once, busReadRequest=0, pcCountEnable=0, state stays IDLE.
- Back-to-back with ProgramCounter wired: PC=4, countEnable from pcCountEnable, fetchStart held 1, instructionAccept=1 each HOLD cycle, zero-wait memory, 8 fetches:
  - busAddress sequence 4, 8, …, 32;
  - exactly 8 pcCountEnable pulses;
  - final PC=36.
- Assert reset for 1 ns mid-REQUEST (asynchronous, between clock edges) → busReadRequest and fetchBusy drop before the next clock edge, instructionValid=0; a subsequent fetch at 0 succeeds.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, busReady never asserted:
  - fetchError pulses after 4 REQUEST cycles, FSM returns to IDLE, no pcCountEnable.
  - Repeat with busReady on the 4th cycle → normal completion.
